// File: rtl/uart_pkg.sv
// Shared types and widths for the UART command assembler slice.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 24;

  // Packet assembly progress: which byte of the 3-byte command comes next.
  typedef enum logic [1:0] {
    WAIT_OP = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } asm_state_t;

  // Assembled command payload, most significant field first.
  typedef struct packed {
    logic [BYTE_W-1:0] opcode;
    logic [BYTE_W-1:0] data_hi;
    logic [BYTE_W-1:0] data_lo;
  } cmd_t;

  // Pack the three command bytes into the flat command word.
  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [BYTE_W-1:0] opcode,
    input logic [BYTE_W-1:0] data_hi,
    input logic [BYTE_W-1:0] data_lo
  );
    cmd_t c;
    c.opcode  = opcode;
    c.data_hi = data_hi;
    c.data_lo = data_lo;
    return CMD_W'(c);
  endfunction

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Receiver-side byte handshake plus consumer-side command handshake.
interface uart_cmd_assembler_if;
  import uart_pkg::*;

  logic              rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              clr_rdy;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic              frame_err;
  logic              overrun;

  // Assembler view.
  modport master (
    input  rdy, rx_data, clr_cmd_rdy,
    output clr_rdy, cmd, cmd_rdy, frame_err, overrun
  );

  // Environment view: UART receiver and command consumer.
  modport slave (
    output rdy, rx_data, clr_cmd_rdy,
    input  clr_rdy, cmd, cmd_rdy, frame_err, overrun
  );

endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: flags expiry when the count reaches TIMEOUT_CYCLES-1.
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned       CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count idle cycles; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire_c = (count == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles 3-byte UART packets into a 24-bit command with timeout and overrun reporting.
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic                  clk,
  input logic                  rst,
  uart_cmd_assembler_if.master bus
);

  asm_state_t        state;
  asm_state_t        state_next;
  logic [BYTE_W-1:0] opcode;
  logic [BYTE_W-1:0] data_hi;
  logic [CMD_W-1:0]  cmd_q;
  logic              cmd_rdy_q;
  logic              overrun_q;

  logic accept;
  logic complete;
  logic timeout;
  logic expire_c;
  logic tmr_clear;
  logic tmr_en;

  // Idle-cycle counter; stays cleared while no packet is in progress.
  uart_cmd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .enable   (tmr_en),
    .expire_c (expire_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_OP;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; an arriving byte always beats expiry.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;

    if (!rst) begin
      accept = bus.rdy;
      unique case (state)
        WAIT_OP: begin
          tmr_clear = 1'b1;
          if (accept) begin
            state_next = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (accept) begin
            state_next = WAIT_LO;
          end else if (expire_c) begin
            timeout    = 1'b1;
            state_next = WAIT_OP;
          end
        end
        WAIT_LO: begin
          if (accept) begin
            complete   = 1'b1;
            state_next = WAIT_OP;
          end else if (expire_c) begin
            timeout    = 1'b1;
            state_next = WAIT_OP;
          end
        end
        default: begin
          state_next = WAIT_OP;
        end
      endcase
      tmr_clear = tmr_clear | accept | timeout;
      tmr_en    = (state != WAIT_OP) && !bus.rdy;
    end
  end

  // Partial packet bytes, kept apart from cmd so cmd stays stable during assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode  <= '0;
      data_hi <= '0;
    end else if (accept) begin
      if (state == WAIT_OP) begin
        opcode <= bus.rx_data;
      end
      if (state == WAIT_HI) begin
        data_hi <= bus.rx_data;
      end
    end
  end

  // Command output register; a completion wins over a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (complete) begin
      cmd_q     <= pack_cmd(opcode, data_hi, bus.rx_data);
      cmd_rdy_q <= 1'b1;
      if (cmd_rdy_q && !bus.clr_cmd_rdy) begin
        overrun_q <= 1'b1;
      end
    end else if (bus.clr_cmd_rdy) begin
      cmd_rdy_q <= 1'b0;
    end
  end

  assign bus.clr_rdy   = accept;
  assign bus.frame_err = timeout;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: directed table, corner sequences, random vs model.
module tb_uart_cmd_assembler;

  localparam int unsigned TO = 16;

  logic clk;
  logic rst;

  uart_cmd_assembler_if bus ();

  uart_cmd_assembler #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;
  bit use_model;

  // Reference model: bytes of the packet in progress, idle time, output state.
  logic [7:0]  mq[$];
  int          m_idle;
  logic [23:0] m_cmd;
  bit          m_crdy;
  bit          m_ov;

  typedef struct {
    bit          r;
    bit          v;
    logic [7:0]  d;
    bit          a;
    bit          e_clr;
    logic [23:0] e_cmd;
    bit          e_crdy;
    bit          e_fe;
    bit          e_ov;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, then advance the model.
  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit a);
    bit e_clr;
    bit e_fe;
    bit comp;
    @(negedge clk);
    rst             = r;
    bus.rdy         = v;
    bus.rx_data     = d;
    bus.clr_cmd_rdy = a;
    #1;
    e_clr = !r && v;
    e_fe  = !r && !v && (mq.size() > 0) && (m_idle == int'(TO) - 1);
    if (use_model) begin
      chk("clr_rdy", 32'(bus.clr_rdy), 32'(e_clr));
      chk("frame_err", 32'(bus.frame_err), 32'(e_fe));
      chk("cmd", 32'(bus.cmd), 32'(m_cmd));
      chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(m_crdy));
      chk("overrun", 32'(bus.overrun), 32'(m_ov));
    end
    comp = 1'b0;
    if (r) begin
      mq.delete();
      m_idle = 0;
      m_cmd  = '0;
      m_crdy = 1'b0;
      m_ov   = 1'b0;
    end else begin
      if (v) begin
        mq.push_back(d);
        m_idle = 0;
        if (mq.size() == 3) begin
          comp = 1'b1;
          if (m_crdy && !a) m_ov = 1'b1;
          m_cmd  = {mq[0], mq[1], mq[2]};
          m_crdy = 1'b1;
          mq.delete();
        end
      end else if (mq.size() > 0) begin
        if (m_idle == int'(TO) - 1) begin
          mq.delete();
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end else begin
        m_idle = 0;
      end
      if (a && !comp) m_crdy = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int pulse_idx;
    int p_rdy;
    checks          = 0;
    errors          = 0;
    use_model       = 1'b0;
    rst             = 1'b1;
    bus.rdy         = 1'b0;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b0;

    //            r  v  d      a  clr cmd        crdy fe ov
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'hA51234, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 24'hA51234, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'hA51234, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 24'hA51234, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'hA51234, 1'b0, 1'b0, 1'b0};

    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Directed table: basic packet, acknowledge, lone byte leaves cmd alone.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].a);
      chk($sformatf("tbl%0d clr_rdy", i), 32'(bus.clr_rdy), 32'(tbl[i].e_clr));
      chk($sformatf("tbl%0d cmd", i), 32'(bus.cmd), 32'(tbl[i].e_cmd));
      chk($sformatf("tbl%0d cmd_rdy", i), 32'(bus.cmd_rdy), 32'(tbl[i].e_crdy));
      chk($sformatf("tbl%0d frame_err", i), 32'(bus.frame_err), 32'(tbl[i].e_fe));
      chk($sformatf("tbl%0d overrun", i), 32'(bus.overrun), 32'(tbl[i].e_ov));
    end

    use_model = 1'b1;

    // Timeout drops a partial packet with exactly one frame_err pulse.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h77);
    pulses    = 0;
    pulse_idx = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (bus.frame_err === 1'b1) begin
        pulses++;
        pulse_idx = i;
      end
    end
    chk("timeout pulse count", 32'(pulses), 32'd1);
    chk("timeout pulse cycle", 32'(pulse_idx), 32'(TO - 1));
    send(8'h10);
    send(8'h20);
    send(8'h30);
    idle(1);
    chk("after timeout cmd", 32'(bus.cmd), 32'h102030);

    // Overrun is sticky until reset.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h01); send(8'h02); send(8'h03);
    send(8'h04); send(8'h05); send(8'h06);
    idle(1);
    chk("overrun cmd", 32'(bus.cmd), 32'h040506);
    chk("overrun set", 32'(bus.overrun), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(3);
    chk("overrun sticky", 32'(bus.overrun), 32'd1);
    chk("overrun ack cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1);
    chk("overrun cleared by rst", 32'(bus.overrun), 32'd0);

    // Acknowledge coincident with completion: no overrun, cmd_rdy stays set.
    send(8'h01); send(8'h02); send(8'h03);
    send(8'h04); send(8'h05);
    step(1'b0, 1'b1, 8'h06, 1'b1);
    idle(1);
    chk("coincident ack overrun", 32'(bus.overrun), 32'd0);
    chk("coincident ack cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("coincident ack cmd", 32'(bus.cmd), 32'h040506);

    // Byte arriving on the expiry cycle is accepted instead of timing out.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h5A);
    idle(int'(TO) - 1);
    step(1'b0, 1'b1, 8'h6B, 1'b0);
    chk("expiry byte clr_rdy", 32'(bus.clr_rdy), 32'd1);
    chk("expiry byte frame_err", 32'(bus.frame_err), 32'd0);
    idle(2);
    send(8'h7C);
    idle(1);
    chk("expiry packet cmd", 32'(bus.cmd), 32'h5A6B7C);
    chk("expiry packet cmd_rdy", 32'(bus.cmd_rdy), 32'd1);

    // Reset mid-packet discards bytes silently.
    send(8'h11);
    send(8'h22);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("rst clr_rdy", 32'(bus.clr_rdy), 32'd0);
    chk("rst frame_err", 32'(bus.frame_err), 32'd0);
    idle(1);
    chk("post rst cmd", 32'(bus.cmd), 32'd0);
    chk("post rst cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    send(8'hAA); send(8'hBB); send(8'hCC);
    idle(1);
    chk("post rst packet", 32'(bus.cmd), 32'hAABBCC);

    // Random traffic with varying byte density so timeouts also occur.
    p_rdy = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       p_rdy = 50;
          1:       p_rdy = 15;
          default: p_rdy = 3;
        endcase
      end
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < p_rdy),
           8'($urandom),
           ($urandom_range(0, 99) < 15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
